// File: rtl/rv32i_multiplier_pkg.sv
// Shared widths, FSM state type and iteration-count helper for the 16x16
// shift-add multiplier.
package rv32i_multiplier_pkg;

  localparam int MULT_OPERAND_W = 16;
  localparam int MULT_RESULT_W  = 32;
  localparam int MULT_CNT_W     = $clog2(MULT_OPERAND_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    RELEASE
  } mult_state_e;

  function automatic int mult_iters(input int bits_per_cycle);
    return MULT_OPERAND_W / bits_per_cycle;
  endfunction

endpackage

// File: rtl/rv32i_multiplier_step.sv
// One shift-add iteration: adds multiplicand x slice to the accumulator as a
// sum of shifted partial terms, one per retired multiplier bit.
module rv32i_multiplier_step
  import rv32i_multiplier_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [MULT_RESULT_W-1:0]  acc_i,
  input  logic [MULT_RESULT_W-1:0]  mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] slice_i,
  output logic [MULT_RESULT_W-1:0]  acc_o
);

  logic [BITS_PER_CYCLE-1:0][MULT_RESULT_W-1:0] term;

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_term
    assign term[j] = slice_i[j] ? (mcand_i << j) : '0;
  end

  always_comb begin
    acc_o = acc_i;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      acc_o = acc_o + term[j];
    end
  end

endmodule

// File: rtl/rv32i_multiplier_16x16.sv
// Iterative 16x16 unsigned multiplier with a hold-until-valid request
// handshake; the requester must drop enable between operations.
module rv32i_multiplier_16x16
  import rv32i_multiplier_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_EXIT     = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_multiplier_en,
  input  logic [MULT_OPERAND_W-1:0] i_multiplier_operand_one,
  input  logic [MULT_OPERAND_W-1:0] i_multiplier_operand_two,
  output logic                      o_multiplier_valid,
  output logic [MULT_RESULT_W-1:0]  o_multiplier_result,
  output logic                      o_multiplier_busy
);

  localparam int                  N    = mult_iters(BITS_PER_CYCLE);
  localparam logic [MULT_CNT_W-1:0] LAST = MULT_CNT_W'(N - 1);

  mult_state_e               state_q, state_d;
  logic [MULT_RESULT_W-1:0]  mcand_q, mcand_d;
  logic [MULT_OPERAND_W-1:0] mplier_q, mplier_d;
  logic [MULT_RESULT_W-1:0]  acc_q, acc_d;
  logic [MULT_CNT_W-1:0]     cnt_q, cnt_d;
  logic [MULT_RESULT_W-1:0]  result_q, result_d;

  logic [MULT_RESULT_W-1:0]  acc_nxt;
  logic [MULT_OPERAND_W-1:0] mplier_shift;

  rv32i_multiplier_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .slice_i(mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (acc_nxt)
  );

  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (i_multiplier_en) begin
          mcand_d  = {{(MULT_RESULT_W-MULT_OPERAND_W){1'b0}}, i_multiplier_operand_one};
          mplier_d = i_multiplier_operand_two;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Dropping enable mid-operation abandons it; result keeps the last product.
        if (!i_multiplier_en) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_shift;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST || (EARLY_EXIT && mplier_shift == '0)) begin
            result_d = acc_nxt;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!i_multiplier_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign o_multiplier_valid  = (state_q == DONE);
  assign o_multiplier_result = result_q;
  assign o_multiplier_busy   = (state_q == BUSY) || (state_q == DONE);

endmodule

// File: tb/tb_rv32i_multiplier_16x16.sv
// Directed bench: three multiplier configurations (1 bit/cycle, 4 bits/cycle,
// 1 bit/cycle with early exit) checked against hand-computed products/latencies.
module tb_rv32i_multiplier_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en    [3];
  logic [15:0] op1   [3];
  logic [15:0] op2   [3];
  logic        valid [3];
  logic [31:0] result[3];
  logic        busy  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_multiplier_16x16 #(.BITS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_multiplier_en(en[0]),
    .i_multiplier_operand_one(op1[0]), .i_multiplier_operand_two(op2[0]),
    .o_multiplier_valid(valid[0]), .o_multiplier_result(result[0]),
    .o_multiplier_busy(busy[0]));

  rv32i_multiplier_16x16 #(.BITS_PER_CYCLE(4), .EARLY_EXIT(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_multiplier_en(en[1]),
    .i_multiplier_operand_one(op1[1]), .i_multiplier_operand_two(op2[1]),
    .o_multiplier_valid(valid[1]), .o_multiplier_result(result[1]),
    .o_multiplier_busy(busy[1]));

  rv32i_multiplier_16x16 #(.BITS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_multiplier_en(en[2]),
    .i_multiplier_operand_one(op1[2]), .i_multiplier_operand_two(op2[2]),
    .o_multiplier_valid(valid[2]), .o_multiplier_result(result[2]),
    .o_multiplier_busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Raise a request; returns #1 after the accepting edge t.
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    en[k]  = 1'b1;
    op1[k] = a;
    op2[k] = b;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(busy[k]), 32'd1);
    chk("no_valid_at_accept", 32'(valid[k]), 32'd0);
  endtask

  // Wait (bounded) for valid; check latency, product and one-cycle width.
  task automatic wait_valid(input int k, input string tag, input int exp_lat,
                            input logic [31:0] exp_res);
    int lat = 0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = valid[k];
    end
    chk({tag, "_latency"}, seen ? 32'(lat) : 32'hDEAD_0000, 32'(exp_lat));
    chk({tag, "_result"}, result[k], exp_res);
    @(posedge clk); #1;
    chk({tag, "_pulse_width"}, 32'(valid[k]), 32'd0);
  endtask

  task automatic release_en(input int k);
    en[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; op1[k] = '0; op2[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", 32'(valid[k]), 32'd0);
      chk("reset_result", result[k], 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;

    // Basic product and exact latency
    issue(0, 16'h0003, 16'h0004);
    wait_valid(0, "t1_3x4", 16, 32'h0000_000C);
    release_en(0);

    // Full-scale operands at both widths
    issue(0, 16'hFFFF, 16'hFFFF);
    wait_valid(0, "t2_ffff_b1", 16, 32'hFFFE_0001);
    release_en(0);
    issue(1, 16'hFFFF, 16'hFFFF);
    wait_valid(1, "t2_ffff_b4", 4, 32'hFFFE_0001);
    release_en(1);
    issue(1, 16'h1234, 16'h0100);
    wait_valid(1, "t2_shift_b4", 4, 32'h0012_3400);
    release_en(1);

    // Enable held after the pulse must not retrigger
    issue(0, 16'h0005, 16'h0007);
    wait_valid(0, "t3_first", 16, 32'h0000_0023);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t3_no_dup_valid", 32'(valid[0]), 32'd0);
      chk("t3_held_not_busy", 32'(busy[0]), 32'd0);
    end
    release_en(0);
    issue(0, 16'h1234, 16'h0100);
    wait_valid(0, "t3_second", 16, 32'h0012_3400);
    release_en(0);

    // Abort mid-operation keeps the previous result
    issue(0, 16'h0005, 16'h0003);
    repeat (6) begin
      @(posedge clk); #1;
    end
    en[0] = 1'b0;
    @(posedge clk); #1;
    chk("t4_abort_busy", 32'(busy[0]), 32'd0);
    chk("t4_abort_result", result[0], 32'h0012_3400);
    begin
      int pulses = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (valid[0]) pulses++;
      end
      chk("t4_abort_no_valid", 32'(pulses), 32'd0);
    end
    issue(0, 16'h8000, 16'h0002);
    wait_valid(0, "t4_after_abort", 16, 32'h0001_0000);
    release_en(0);

    // Reset in the middle of an operation
    issue(0, 16'h00FF, 16'h0101);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst   = 1'b1;
    en[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_valid", 32'(valid[0]), 32'd0);
    chk("t5_rst_result", result[0], 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    issue(0, 16'h0007, 16'h0009);
    wait_valid(0, "t5_after_rst", 16, 32'h0000_003F);
    release_en(0);

    // Early exit
    issue(2, 16'hABCD, 16'h0001);
    wait_valid(2, "t6_x1", 1, 32'h0000_ABCD);
    release_en(2);
    issue(2, 16'h1234, 16'h0000);
    wait_valid(2, "t6_x0", 1, 32'h0000_0000);
    release_en(2);
    issue(2, 16'h0003, 16'h8000);
    wait_valid(2, "t6_x8000", 16, 32'h0001_8000);
    release_en(2);
    issue(2, 16'h0011, 16'h0010);
    wait_valid(2, "t6_x0010", 5, 32'h0000_0110);
    release_en(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_multiplier_16x16.md
Name: rv32i_multiplier_16x16

Overview:
Iterative 16x16 unsigned shift-add multiplier that serves as the multiplier IP for the execute-stage shift/multiply control path. It sits directly downstream of that control path. The control path drives enable and two 16-bit operands; this block returns a single-cycle valid pulse with a 32-bit product. The control path issues sub-word multiplies for barrel shifting (operand two is a power of two) and holds each request until the result returns.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values are 1, 2 and 4; iteration count N = 16/BITS_PER_CYCLE.
EARLY_EXIT, 0, when 1, finish as soon as the remaining unprocessed bits of operand two are all zero.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_multiplier_en  input  1  request; held high with stable operands until valid is seen.
i_multiplier_operand_one  input  16  multiplicand (unsigned).
i_multiplier_operand_two  input  16  multiplier (unsigned).
o_multiplier_valid  output  1  one-cycle pulse; result is valid in the same cycle.
o_multiplier_result  output  32  product of operand one and operand two.
o_multiplier_busy  output  1  high in BUSY and DONE states (debug/perf use).

Behaviour:
- Reset (i_rst high at an edge, from any state): state = IDLE, valid = 0, result = 0, busy = 0, internal accumulator and counter cleared. Reset has priority over every other event.
- States are IDLE, BUSY, DONE and RELEASE.
- IDLE: if en is sampled high at edge t:
  - latch operand one zero-extended to 32 bits into the multiplicand register;
  - latch operand two into the multiplier register;
  - clear the accumulator and counter; go to BUSY.
  - Operands are never re-sampled after this edge.
- BUSY, each edge:
  - accumulator += multiplicand × (low BITS_PER_CYCLE bits of multiplier), via shift-add of partial terms;
  - multiplicand shifts left by BITS_PER_CYCLE; multiplier shifts right by BITS_PER_CYCLE; counter increments.
  - The accumulator is 32 bits wide; the product never exceeds 32 bits, so there is no overflow.
- Completion in BUSY:
  - On the iteration where counter == N-1, or (EARLY_EXIT and the shifted-out multiplier is 0): register result = final accumulator, valid <= 1, go to DONE.
  - Fixed latency with EARLY_EXIT=0: valid rises at edge t+N (16 cycles for BITS_PER_CYCLE=1, 4 for BITS_PER_CYCLE=4).
  - Operand two == 0 with EARLY_EXIT=1: valid at edge t+1 with result 0.
- DONE: lasts exactly one cycle with valid = 1. At the next edge valid <= 0 and the state goes to RELEASE.
- RELEASE: wait until en is sampled low, then go to IDLE.
  - A requester that holds en high after the valid pulse never triggers a duplicate operation.
  - The requester must drop en for at least one cycle between requests. The minimum gap from valid to the next accepted request is 2 edges.
- Abort: en sampled low while in BUSY sends the state to IDLE with no valid pulse. The result register keeps its previous value.
- o_multiplier_result holds the last completed product until the next completion or reset. It is never updated during BUSY.
- valid is never asserted outside the cycle immediately following a completion edge.

Decomposition:
- Package rv32i_multiplier_pkg:
  - MULT_OPERAND_W = 16 and MULT_RESULT_W = 32;
  - the state enum type (IDLE, BUSY, DONE, RELEASE);
  - a function returning N for a given BITS_PER_CYCLE.
- One sub-module, rv32i_multiplier_step:
  - purely combinational, parameterised by BITS_PER_CYCLE;
  - inputs: accumulator, multiplicand and multiplier slice;
  - output: next accumulator.
- The top module holds the FSM, registers and handshake.

Test Plan:
1. BITS_PER_CYCLE=1: en high at edge t with 0x0003 and 0x0004 -> valid pulses exactly at edge t+16, result = 0x0000000C, one cycle wide.
2. 0xFFFF × 0xFFFF (BITS_PER_CYCLE=1 and 4) -> result = 0xFFFE0001 at edge t+16 and t+4 respectively.
3. en held high for 5 cycles after the valid pulse, then dropped for 1 cycle, then raised with 0x1234 and 0x0100 -> exactly one valid for the first request; second result = 0x00123400; no spurious valid.
4. en dropped at the 7th BUSY cycle -> no valid; the result register keeps its prior value. A new request with 0x8000 and 0x0002 then returns 0x00010000.
5. i_rst asserted at the 10th BUSY cycle -> next cycle valid = 0, result = 0, busy = 0. A following request completes normally with full latency.
6. EARLY_EXIT=1, BITS_PER_CYCLE=1: operand two 0x0001 -> valid at edge t+1 with the result equal to operand one; operand two 0x0000 -> result 0 at t+1; operand two 0x8000 -> valid at t+16.
